// File: rtl/usb_rx_decoder.sv
// USB receive bit path: NRZI decode, SYNC match, bit unstuffing, LSB-first byte assembly and EOP checks.
// Pulses appear one clk after the consuming sample_en; no backpressure, bytes must be taken on byte_valid.
module usb_rx_decoder #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         MAX_ONES     = 6,
    parameter int         IDLE_J_COUNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       rx_enable,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       packet_start,
    output logic       packet_done,
    output logic       rx_active,
    output logic       stuff_err,
    output logic       eop_err
);
    localparam int OW = $clog2(MAX_ONES + 1);
    localparam int IW = $clog2(IDLE_J_COUNT + 1);
    localparam logic [OW-1:0] L_MAX_ONES  = OW'(MAX_ONES);
    localparam logic [IW-1:0] L_IDLE_LAST = IW'(IDLE_J_COUNT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_prev_j, w_prev_j_nxt;
    logic [7:0]    r_sr, w_sr_nxt;
    logic [7:0]    r_rx_byte, w_rx_byte_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [OW-1:0] r_ones_cnt, w_ones_cnt_nxt;
    logic [1:0]    r_se0_cnt, w_se0_cnt_nxt;
    logic [IW-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic          r_byte_valid, w_byte_valid_nxt;
    logic          r_packet_start, w_packet_start_nxt;
    logic          r_packet_done, w_packet_done_nxt;
    logic          r_stuff_err, w_stuff_err_nxt;
    logic          r_eop_err, w_eop_err_nxt;
    logic          w_go_err;

    logic       w_is_j, w_is_k, w_is_se0, w_is_se1, w_bit;
    logic [7:0] w_sr_shift;

    assign w_is_j     = d_plus_sync & ~d_minus_sync;
    assign w_is_k     = ~d_plus_sync & d_minus_sync;
    assign w_is_se0   = ~d_plus_sync & ~d_minus_sync;
    assign w_is_se1   = d_plus_sync & d_minus_sync;
    // NRZI: no transition decodes as 1; only meaningful on J/K samples.
    assign w_bit      = (d_plus_sync == r_prev_j);
    assign w_sr_shift = {w_bit, r_sr[7:1]};

    always_comb begin
        w_state_nxt        = r_state;
        w_prev_j_nxt       = r_prev_j;
        w_sr_nxt           = r_sr;
        w_rx_byte_nxt      = r_rx_byte;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_ones_cnt_nxt     = r_ones_cnt;
        w_se0_cnt_nxt      = r_se0_cnt;
        w_idle_cnt_nxt     = r_idle_cnt;
        w_byte_valid_nxt   = 1'b0;
        w_packet_start_nxt = 1'b0;
        w_packet_done_nxt  = 1'b0;
        w_stuff_err_nxt    = 1'b0;
        w_eop_err_nxt      = 1'b0;
        w_go_err           = 1'b0;
        if (!rx_enable) begin
            w_state_nxt    = S_IDLE;
            w_prev_j_nxt   = 1'b1;
            w_bit_cnt_nxt  = '0;
            w_ones_cnt_nxt = '0;
            w_se0_cnt_nxt  = '0;
            w_idle_cnt_nxt = '0;
        end else if (sample_en) begin
            if (w_is_j || w_is_k) begin
                w_prev_j_nxt = w_is_j;
            end else if (w_is_se0) begin
                w_prev_j_nxt = 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_is_k) begin
                        w_state_nxt   = S_SYNC;
                        w_sr_nxt      = w_sr_shift;
                        w_bit_cnt_nxt = 3'd1;
                    end
                end
                S_SYNC: begin
                    if (!(w_is_j || w_is_k)) begin
                        w_eop_err_nxt = 1'b1;
                        w_go_err      = 1'b1;
                    end else begin
                        w_sr_nxt      = w_sr_shift;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_sr_shift == SYNC_PATTERN) begin
                                w_packet_start_nxt = 1'b1;
                                w_state_nxt        = S_DATA;
                                w_ones_cnt_nxt     = OW'(1);
                                w_bit_cnt_nxt      = '0;
                            end else begin
                                w_eop_err_nxt = 1'b1;
                                w_go_err      = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_is_se1) begin
                        w_eop_err_nxt = 1'b1;
                        w_go_err      = 1'b1;
                    end else if (w_is_se0) begin
                        w_state_nxt   = S_EOP;
                        w_se0_cnt_nxt = 2'd1;
                    end else if (r_ones_cnt == L_MAX_ONES) begin
                        // Mandatory stuffed zero: dropped, never shifted into the byte.
                        if (w_bit) begin
                            w_stuff_err_nxt = 1'b1;
                            w_go_err        = 1'b1;
                        end else begin
                            w_ones_cnt_nxt = '0;
                        end
                    end else begin
                        w_ones_cnt_nxt = w_bit ? r_ones_cnt + 1'b1 : '0;
                        w_sr_nxt       = w_sr_shift;
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_byte_nxt    = w_sr_shift;
                            w_byte_valid_nxt = 1'b1;
                        end
                    end
                end
                S_EOP: begin
                    if (w_is_se0) begin
                        if (r_se0_cnt == 2'd2) begin
                            w_eop_err_nxt = 1'b1;
                            w_go_err      = 1'b1;
                        end else begin
                            w_se0_cnt_nxt = r_se0_cnt + 2'd1;
                        end
                    end else if (w_is_j) begin
                        w_packet_done_nxt = (r_bit_cnt == 3'd0);
                        w_eop_err_nxt     = (r_bit_cnt != 3'd0);
                        w_state_nxt       = S_IDLE;
                        w_bit_cnt_nxt     = '0;
                        w_ones_cnt_nxt    = '0;
                        w_se0_cnt_nxt     = '0;
                    end else begin
                        w_eop_err_nxt = 1'b1;
                        w_go_err      = 1'b1;
                    end
                end
                S_ERROR: begin
                    if (w_is_j) begin
                        if (r_idle_cnt == L_IDLE_LAST) begin
                            w_state_nxt    = S_IDLE;
                            w_idle_cnt_nxt = '0;
                        end else begin
                            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                        end
                    end else begin
                        w_idle_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_go_err) begin
                w_state_nxt    = S_ERROR;
                w_idle_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_prev_j       <= 1'b1;
            r_sr           <= '0;
            r_rx_byte      <= '0;
            r_bit_cnt      <= '0;
            r_ones_cnt     <= '0;
            r_se0_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_byte_valid   <= 1'b0;
            r_packet_start <= 1'b0;
            r_packet_done  <= 1'b0;
            r_stuff_err    <= 1'b0;
            r_eop_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_prev_j       <= w_prev_j_nxt;
            r_sr           <= w_sr_nxt;
            r_rx_byte      <= w_rx_byte_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_ones_cnt     <= w_ones_cnt_nxt;
            r_se0_cnt      <= w_se0_cnt_nxt;
            r_idle_cnt     <= w_idle_cnt_nxt;
            r_byte_valid   <= w_byte_valid_nxt;
            r_packet_start <= w_packet_start_nxt;
            r_packet_done  <= w_packet_done_nxt;
            r_stuff_err    <= w_stuff_err_nxt;
            r_eop_err      <= w_eop_err_nxt;
        end
    end

    assign rx_byte      = r_rx_byte;
    assign byte_valid   = r_byte_valid;
    assign packet_start = r_packet_start;
    assign packet_done  = r_packet_done;
    assign stuff_err    = r_stuff_err;
    assign eop_err      = r_eop_err;
    assign rx_active    = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_EOP);

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: a line-level USB encoder builds packets and the events they must produce;
// observed output pulses are collected per scenario and compared against that expectation.
module tb_usb_rx_decoder;
    logic       clk = 1'b0;
    logic       rst, sample_en, rx_enable, d_plus_sync, d_minus_sync;
    logic [7:0] rx_byte;
    logic       byte_valid, packet_start, packet_done, rx_active, stuff_err, eop_err;

    localparam logic [31:0] EV_START  = 32'h100;
    localparam logic [31:0] EV_BYTE   = 32'h200;
    localparam logic [31:0] EV_DONE   = 32'h300;
    localparam logic [31:0] EV_STUFF  = 32'h400;
    localparam logic [31:0] EV_EOPERR = 32'h500;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic        last_se   = 1'b0;
    logic        tb_lvl_j  = 1'b1;
    int          tb_ones   = 0;
    int          tb_bits   = 0;
    logic [7:0]  tb_cur    = 8'h00;
    logic [7:0]  last_byte = 8'h00;

    usb_rx_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .rx_enable    (rx_enable),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .packet_start (packet_start),
        .packet_done  (packet_done),
        .rx_active    (rx_active),
        .stuff_err    (stuff_err),
        .eop_err      (eop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every pulse must follow a strobe cycle directly.
    always @(negedge clk) begin
        if (packet_start) obs_q.push_back(EV_START);
        if (byte_valid)   obs_q.push_back(EV_BYTE | {24'h0, rx_byte});
        if (packet_done)  obs_q.push_back(EV_DONE);
        if (stuff_err)    obs_q.push_back(EV_STUFF);
        if (eop_err)      obs_q.push_back(EV_EOPERR);
        if (byte_valid | packet_start | packet_done | stuff_err | eop_err)
            check("pulse_after_strobe", {31'h0, last_se}, 32'h1);
        if (byte_valid)
            check("byte_valid_exclusive", {30'h0, packet_done, stuff_err}, 32'h0);
        last_se = sample_en;
    end

    task automatic strobe(input logic dp, input logic dm);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        d_plus_sync  = dp;
        d_minus_sync = dm;
        sample_en    = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic send_j();   strobe(1'b1, 1'b0); tb_lvl_j = 1'b1; endtask
    task automatic send_k();   strobe(1'b0, 1'b1); tb_lvl_j = 1'b0; endtask
    task automatic send_se0(); strobe(1'b0, 1'b0); tb_lvl_j = 1'b1; endtask

    task automatic idle_js(input int n);
        repeat (n) send_j();
    endtask

    // NRZI encode: a 0 toggles the line, a 1 holds it.
    task automatic send_bit(input logic b);
        if (!b) tb_lvl_j = ~tb_lvl_j;
        strobe(tb_lvl_j, ~tb_lvl_j);
    endtask

    task automatic send_sync();
        logic [7:0] pat;
        pat      = 8'h80;
        tb_lvl_j = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(pat[i]);
        tb_ones = 1;
        tb_bits = 0;
        exp_q.push_back(EV_START);
        check("active_after_sync", {31'h0, rx_active}, 32'h1);
    endtask

    task automatic send_data_bit(input logic b, input logic do_stuff);
        send_bit(b);
        tb_cur[tb_bits[2:0]] = b;
        tb_bits++;
        if (tb_bits == 8) begin
            exp_q.push_back(EV_BYTE | {24'h0, tb_cur});
            last_byte = tb_cur;
            tb_bits   = 0;
        end
        tb_ones = b ? tb_ones + 1 : 0;
        if (do_stuff && tb_ones == 6) begin
            send_bit(1'b0);
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i], 1'b1);
    endtask

    task automatic finish_scenario(input string tag);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_event"}, (i < obs_q.size()) ? obs_q[i] : 32'hFFFF_FFFF, exp_q[i]);
        check({tag, "_rx_byte_held"}, {24'h0, rx_byte}, {24'h0, last_byte});
        check({tag, "_active_idle"}, {31'h0, rx_active}, 32'h0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_kind(input int kind, input int nb);
        logic [7:0] v;
        int         extra;
        extra = $urandom_range(1, 7);
        idle_js($urandom_range(1, 3));
        if (kind == 4) begin
            v    = 8'($urandom);
            v[0] = 1'b0;
            if (v == 8'h80) v = 8'h00;
            tb_lvl_j = 1'b1;
            for (int i = 0; i < 8; i++) send_bit(v[i]);
            exp_q.push_back(EV_EOPERR);
            idle_js(8);
        end else begin
            send_sync();
            for (int i = 0; i < nb; i++) send_byte(8'($urandom));
            case (kind)
                0: begin
                    repeat ($urandom_range(1, 2)) send_se0();
                    send_j();
                    exp_q.push_back(EV_DONE);
                end
                1: begin
                    repeat (extra) send_data_bit(1'($urandom), 1'b1);
                    send_se0();
                    send_se0();
                    send_j();
                    exp_q.push_back(EV_EOPERR);
                end
                2: begin
                    while (tb_ones < 6) send_data_bit(1'b1, 1'b0);
                    send_bit(1'b1);
                    exp_q.push_back(EV_STUFF);
                    check("stuff_active_low", {31'h0, rx_active}, 32'h0);
                    idle_js(7);
                    send_k();
                    check("error_needs_8_j", {31'h0, rx_active}, 32'h0);
                    idle_js(8);
                end
                3: begin
                    repeat (3) send_se0();
                    exp_q.push_back(EV_EOPERR);
                    idle_js(8);
                end
                5: begin
                    repeat (extra) send_data_bit(1'($urandom), 1'b1);
                    rx_enable = 1'b0;
                    strobe(1'b0, 1'b1);
                    check("disable_active_low", {31'h0, rx_active}, 32'h0);
                    rx_enable = 1'b1;
                end
                6: begin
                    repeat (extra) send_data_bit(1'($urandom), 1'b1);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    last_byte = 8'h00;
                    check("midrst_rx_byte", {24'h0, rx_byte}, 32'h0);
                    check("midrst_active", {31'h0, rx_active}, 32'h0);
                end
                7: begin
                    strobe(1'b1, 1'b1);
                    exp_q.push_back(EV_EOPERR);
                    idle_js(8);
                end
                default: begin
                    send_se0();
                    send_k();
                    exp_q.push_back(EV_EOPERR);
                    idle_js(8);
                end
            endcase
        end
        finish_scenario($sformatf("kind%0d", kind));
    endtask

    initial begin
        rst          = 1'b1;
        sample_en    = 1'b0;
        rx_enable    = 1'b1;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_byte", {24'h0, rx_byte}, 32'h0);
        check("reset_active", {31'h0, rx_active}, 32'h0);
        check("reset_pulses", {27'h0, byte_valid, packet_start, packet_done, stuff_err, eop_err}, 32'h0);
        rst = 1'b0;

        idle_js(2);
        send_sync();
        send_byte(8'hA5);
        send_se0();
        send_se0();
        check("a5_active_in_eop", {31'h0, rx_active}, 32'h1);
        send_j();
        exp_q.push_back(EV_DONE);
        check("a5_active_after_j", {31'h0, rx_active}, 32'h0);
        finish_scenario("pkt_a5");

        idle_js(2);
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_se0();
        send_se0();
        send_j();
        exp_q.push_back(EV_DONE);
        finish_scenario("pkt_ff00");

        run_kind(2, 0);

        idle_js(2);
        send_sync();
        send_byte(8'h3C);
        repeat (4) send_data_bit(1'($urandom), 1'b1);
        send_se0();
        send_se0();
        send_j();
        exp_q.push_back(EV_EOPERR);
        finish_scenario("pkt_3c_misaligned");

        idle_js(2);
        tb_lvl_j = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        exp_q.push_back(EV_EOPERR);
        idle_js(8);
        finish_scenario("bad_sync");

        run_kind(3, 1);
        run_kind(5, 1);
        run_kind(6, 2);

        for (int n = 0; n < 80; n++) run_kind($urandom_range(0, 8), $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
